// File: rtl/hb_filter_pkg.sv
// hb_filter_pkg: shared widths, Q15 half-band coefficients and
// sample/accumulator types for the hb_filter datapath.
package hb_filter_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 36;
    localparam int PRE_W  = DATA_W + 1;
    localparam int FRAC_W = 15;

    // Non-zero half-band coefficients (Q1.15); odd taps are zero.
    localparam int H0 = 983;
    localparam int H2 = -2621;
    localparam int H4 = 9830;
    localparam int HC = 16384;

    // log2(HC): the centre term is a shift, not a multiply.
    localparam int HC_SHIFT = 14;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [PRE_W-1:0]  pre_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Symmetric pre-add of two taps at one bit of growth.
    function automatic pre_t pre_add(input sample_t a, input sample_t b);
        return pre_t'(a) + pre_t'(b);
    endfunction

    // Pre-add times coefficient, sign-extended to accumulator width.
    function automatic acc_t mul_pre(input pre_t p, input coef_t c);
        return acc_t'(p) * acc_t'(c);
    endfunction

endpackage

// File: rtl/hb_round_sat.sv
// hb_round_sat: rounds the 36-bit Q15 accumulator half-up to 16 bits.
// Ports: acc (accumulator in), y (rounded sample out, combinational).
// HB_SAT_EN defined: clamp to [-32768, 32767]; undefined: wrap.
module hb_round_sat
    import hb_filter_pkg::*;
(
    input  acc_t    acc,
    output sample_t y
);

    localparam acc_t HALF_LSB = acc_t'(1) <<< (FRAC_W - 1);

    acc_t rnd;

    // Adding half an output LSB then flooring rounds ties toward +inf.
    assign rnd = (acc + HALF_LSB) >>> FRAC_W;

`ifdef HB_SAT_EN

    localparam acc_t SAT_HI = acc_t'(32767);
    localparam acc_t SAT_LO = -acc_t'(32768);

    always_comb begin
        y = rnd[DATA_W-1:0];
        if (rnd > SAT_HI) begin
            y = sample_t'(16'sh7fff);
        end else if (rnd < SAT_LO) begin
            y = sample_t'(16'sh8000);
        end
    end

`else

    // Upper bits are intentionally dropped: two's-complement wrap.
    logic unused_hi;

    assign unused_hi = ^rnd[ACC_W-1:DATA_W];
    assign y = rnd[DATA_W-1:0];

`endif

endmodule

// File: rtl/hb_filter.sv
// hb_filter: 11-tap symmetric Q15 half-band FIR, one sample per clock.
// Ports: clk, reset_n (async, ACTIVE-HIGH despite its name),
//        x_in (signed sample in), y_out (registered signed sample out).
// Build option HB_SAT_EN: saturate instead of wrap on overflow.
module hb_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 11
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [DATA_W-1:0] y_out
);

    import hb_filter_pkg::*;

    localparam logic signed [COEF_W-1:0] C0 = COEF_W'(H0);
    localparam logic signed [COEF_W-1:0] C2 = COEF_W'(H2);
    localparam logic signed [COEF_W-1:0] C4 = COEF_W'(H4);

    localparam int MID = (NTAPS - 1) / 2;
    localparam int LST = NTAPS - 1;

    logic signed [DATA_W-1:0] taps [NTAPS];

    pre_t    pre0;
    pre_t    pre2;
    pre_t    pre4;
    acc_t    prod0;
    acc_t    prod2;
    acc_t    prod4;
    acc_t    prodc;
    acc_t    acc;
    sample_t y_rnd;

    // Taps mirrored about the centre share one coefficient.
    assign pre0 = pre_add(taps[0], taps[LST]);
    assign pre2 = pre_add(taps[2], taps[LST-2]);
    assign pre4 = pre_add(taps[4], taps[LST-4]);

    assign prod0 = mul_pre(pre0, C0);
    assign prod2 = mul_pre(pre2, C2);
    assign prod4 = mul_pre(pre4, C4);

    // Centre coefficient is exactly 0.5, so it reduces to a shift.
    assign prodc = acc_t'(taps[MID]) <<< HC_SHIFT;

    // Odd taps (other than the centre) have zero weight and are skipped.
    assign acc = prod0 + prod2 + prod4 + prodc;

    hb_round_sat u_round_sat (
        .acc (acc),
        .y   (y_rnd)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                taps[i] <= '0;
            end
            y_out <= '0;
        end else begin
            taps[0] <= x_in;
            for (int i = 1; i < NTAPS; i++) begin
                taps[i] <= taps[i-1];
            end
            y_out <= y_rnd;
        end
    end

endmodule

// File: tb/tb_hb_filter.sv
// tb_hb_filter: scoreboard bench for hb_filter (direct-form reference
// convolution, plus fixed expected tables for impulse/DC/Nyquist/overflow).
module tb_hb_filter;

    logic               clk;
    logic               reset_n;
    logic signed [15:0] x_in;
    logic signed [15:0] y_out;

    int n_cmp = 0;
    int n_bad = 0;

    int hist [11];
    logic signed [15:0] sb [$];

    const int coef [11] = '{983, 0, -2621, 0, 9830, 16384,
                            9830, 0, -2621, 0, 983};

    hb_filter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x_in    (x_in),
        .y_out   (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full direct-form convolution over all 11 taps.
    function automatic logic signed [15:0] model();
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < 11; i++) begin
            acc += longint'(hist[i]) * longint'(coef[i]);
        end
        r = (acc + 64'sd16384) >>> 15;
`ifdef HB_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return 16'(r);
    endfunction

    // Drive one sample; y_out after this edge depends on the taps
    // held before it, so the expectation is taken before the shift.
    task automatic step(input logic signed [15:0] x);
        x_in = x;
        sb.push_back(model());
        for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(x);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b1;
        x_in = '0;
        for (int i = 0; i < 11; i++) hist[i] = 0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    task automatic test_reset();
        logic signed [15:0] exp;
        reset_n = 1'b1;
        x_in = '0;
        #2;
        n_cmp++;
        if (y_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_init: got %0d expected 0", y_out);
        end
        apply_reset();
        for (int n = 0; n < 20; n++) begin
            step(16'($urandom));
            exp = sb.pop_front();
            n_cmp++;
            if (y_out !== exp) begin
                n_bad++;
                $display("FAIL reset_pre: got %0d expected %0d", y_out, exp);
            end
        end
        // Find a non-zero output so the async clear is observable.
        for (int n = 0; n < 20 && y_out == 0; n++) begin
            step(16'sd20000);
            void'(sb.pop_front());
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (y_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_async: got %0d expected 0", y_out);
        end
        x_in = 16'sd12345;
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_out !== 16'sd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %0d expected 0", y_out);
        end
        x_in = '0;
        for (int i = 0; i < 11; i++) hist[i] = 0;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b0;
        for (int n = 0; n < 14; n++) begin
            step(16'sd0);
            void'(sb.pop_front());
            n_cmp++;
            if (y_out !== 16'sd0) begin
                n_bad++;
                $display("FAIL reset_after: got %0d expected 0", y_out);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [15:0] exp;
        logic signed [15:0] imp [11];
        imp = '{16'sd492, 16'sd0, -16'sd1310, 16'sd0, 16'sd4915, 16'sd8192,
                16'sd4915, 16'sd0, -16'sd1310, 16'sd0, 16'sd492};
        apply_reset();
        step(16'sd0);
        void'(sb.pop_front());
        step(16'sd16384);
        void'(sb.pop_front());
        for (int j = 0; j < 16; j++) begin
            step(16'sd0);
            exp = sb.pop_front();
            n_cmp++;
            if (y_out !== exp) begin
                n_bad++;
                $display("FAIL impulse_model[%0d]: got %0d expected %0d",
                         j, y_out, exp);
            end
            exp = (j < 11) ? imp[j] : 16'sd0;
            n_cmp++;
            if (y_out !== exp) begin
                n_bad++;
                $display("FAIL impulse_tab[%0d]: got %0d expected %0d",
                         j, y_out, exp);
            end
        end
    endtask

    task automatic test_dc(input logic signed [15:0] lvl);
        logic signed [15:0] exp;
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            step(lvl);
            exp = sb.pop_front();
            n_cmp++;
            if (y_out !== exp) begin
                n_bad++;
                $display("FAIL dc_model[%0d]: got %0d expected %0d",
                         n, y_out, exp);
            end
            if (n >= 11) begin
                n_cmp++;
                if (y_out !== lvl) begin
                    n_bad++;
                    $display("FAIL dc_level[%0d]: got %0d expected %0d",
                             n, y_out, lvl);
                end
            end
        end
    endtask

    task automatic test_nyquist();
        logic signed [15:0] exp;
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            step((n % 2 == 0) ? 16'sd10000 : -16'sd10000);
            exp = sb.pop_front();
            n_cmp++;
            if (y_out !== exp) begin
                n_bad++;
                $display("FAIL nyq_model[%0d]: got %0d expected %0d",
                         n, y_out, exp);
            end
            if (n >= 11) begin
                n_cmp++;
                if (y_out !== 16'sd0) begin
                    n_bad++;
                    $display("FAIL nyq_null[%0d]: got %0d expected 0",
                             n, y_out);
                end
            end
        end
    endtask

    task automatic test_overflow(input bit neg, input logic signed [15:0] want);
        logic signed [15:0] exp;
        logic signed [15:0] hi;
        logic signed [15:0] lo;
        logic signed [15:0] pat [11];
        hi = neg ? -16'sd32768 : 16'sd32767;
        lo = neg ? 16'sd32767 : -16'sd32768;
        for (int i = 0; i < 11; i++) pat[i] = 16'sd0;
        pat[0] = hi; pat[4] = hi; pat[5] = hi; pat[6] = hi; pat[10] = hi;
        pat[2] = lo; pat[8] = lo;
        apply_reset();
        // Oldest sample first so that tap[i] ends up holding pat[i].
        for (int i = 10; i >= 0; i--) begin
            step(pat[i]);
            void'(sb.pop_front());
        end
        step(16'sd0);
        exp = sb.pop_front();
        n_cmp++;
        if (y_out !== exp) begin
            n_bad++;
            $display("FAIL ovf_model: got %0d expected %0d", y_out, exp);
        end
        n_cmp++;
        if (y_out !== want) begin
            n_bad++;
            $display("FAIL ovf_value: got %0d expected %0d", y_out, want);
        end
    endtask

    task automatic test_stream();
        logic signed [15:0] exp;
        int bad_here;
        bad_here = 0;
        apply_reset();
        for (int n = 0; n < 10000; n++) begin
            step(16'($urandom));
            exp = sb.pop_front();
            n_cmp++;
            if (y_out !== exp) begin
                n_bad++;
                bad_here++;
                if (bad_here <= 10) begin
                    $display("FAIL stream[%0d]: got %0d expected %0d",
                             n, y_out, exp);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        x_in = '0;
        for (int i = 0; i < 11; i++) hist[i] = 0;
        test_reset();
        test_impulse();
        test_dc(16'sd10000);
        test_dc(-16'sd32768);
        test_nyquist();
`ifdef HB_SAT_EN
        test_overflow(1'b0, 16'sd32767);
        test_overflow(1'b1, -16'sd32768);
`else
        test_overflow(1'b0, -16'sd22285);
        test_overflow(1'b1, 16'sd22284);
`endif
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
